// File: rtl/msaw_demod.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : msaw_demod                                                     |
// | Purpose  : Recovers the 8-bit modulation word M from a modulated          |
// |            sawtooth (MSAW) sample stream. The peak of each period is      |
// |            tracked, then a 20-step sequential restoring divider computes  |
// |            M = ceil(peak*128/AMP) once per period.                        |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
// | Parameters                                                               |
// |   NP   generator period minus 1 (one period = NP+1 ce samples)           |
// |   AMP  unmodulated sawtooth peak, 128 < AMP <= 4095                       |
// | Ports                                                                    |
// |   clk      in   1   system clock                                         |
// |   rst_n    in   1   asynchronous active-low reset                        |
// |   ce       in   1   sample strobe for MSAW / CO_MSAW                     |
// |   MSAW     in  12   modulated sawtooth sample                             |
// |   CO_MSAW  in   1   period marker, high on the last (peak) sample         |
// |   M_est    out  8   recovered modulation word, held between updates       |
// |   M_valid  out  1   one-clock pulse when M_est / PER_ERR update           |
// |   PER_ERR  out  1   reported period length differed from NP+1             |
// |   OVR      out  1   sticky: period end seen while divider busy            |
// |   busy     out  1   divider running                                       |
// | Build option                                                             |
// |   MSAW_DEMOD_AUTOSYNC_EN : derive the period boundary from a falling     |
// |   MSAW sample instead of CO_MSAW (CO_MSAW is then ignored). A constant   |
// |   zero input never produces a boundary, so M=0 is never reported.        |
// +--------------------------------------------------------------------------+
module msaw_demod #(
  parameter int NP  = 100,
  parameter int AMP = 4000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  input  logic [11:0] MSAW,
  input  logic        CO_MSAW,
  output logic [7:0]  M_est,
  output logic        M_valid,
  output logic        PER_ERR,
  output logic        OVR,
  output logic        busy
);

  localparam logic [11:0] C_AMP   = 12'(AMP);
  localparam logic [19:0] C_BIAS  = 20'(AMP - 1);  // turns floor into ceil
  localparam logic [8:0]  C_PER   = 9'(NP + 1);
  localparam logic [4:0]  C_LAST  = 5'd19;         // index of final divider step

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_ACQ  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] peak_q, peak_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cnt_end_q, cnt_end_d;
  logic [11:0] rem_q, rem_d;
  logic [19:0] dvd_q, dvd_d;
  logic [18:0] quo_q, quo_d;
  logic [4:0]  iter_q, iter_d;
  logic [7:0]  m_est_q, m_est_d;
  logic        m_valid_q, m_valid_d;
  logic        per_err_q, per_err_d;
  logic        ovr_q, ovr_d;

  // Period-boundary dependent terms
  logic        per_end;       // this ce sample closes a period
  logic [11:0] pk;            // peak of the period being closed
  logic [7:0]  cnt_close;     // sample count of the period being closed
  logic [11:0] peak_restart;  // peak value the next period starts from
  logic [7:0]  cnt_restart;   // sample count the next period starts from

  logic [11:0] peak_max;
  logic [7:0]  cnt_inc;

  assign peak_max = (MSAW > peak_q) ? MSAW : peak_q;
  assign cnt_inc  = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;

`ifdef MSAW_DEMOD_AUTOSYNC_EN
  logic [11:0] prev_q, prev_d;
  logic        co_msaw_unused;

  assign co_msaw_unused = CO_MSAW;
  // The falling sample is the first sample of the new period, so it is
  // excluded from the closing peak and seeds the next one.
  assign per_end      = ce && (MSAW < prev_q);
  assign pk           = peak_q;
  assign cnt_close    = cnt_q;
  assign peak_restart = MSAW;
  assign cnt_restart  = 8'd1;
  assign prev_d       = ce ? MSAW : prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 12'd0;
    end else begin
      prev_q <= prev_d;
    end
  end
`else
  // The marked sample is the last (peak) sample of the closing period.
  assign per_end      = ce && CO_MSAW;
  assign pk           = peak_max;
  assign cnt_close    = cnt_inc;
  assign peak_restart = 12'd0;
  assign cnt_restart  = 8'd0;
`endif

  // One restoring-division step: shift the next dividend bit into the
  // partial remainder and subtract the divisor when it fits.
  logic [12:0] div_trial;
  logic        div_ge;
  logic [11:0] div_diff;
  logic [19:0] quo_next;

  assign div_trial = {rem_q, dvd_q[19]};
  assign div_ge    = (div_trial >= {1'b0, C_AMP});
  // Remainder after subtraction is below AMP, so 12 bits hold it exactly.
  assign div_diff  = div_trial[11:0] - C_AMP;
  assign quo_next  = {quo_q, div_ge};

  always_comb begin
    state_d   = state_q;
    peak_d    = peak_q;
    cnt_d     = cnt_q;
    cnt_end_d = cnt_end_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    quo_d     = quo_q;
    iter_d    = iter_q;
    m_est_d   = m_est_q;
    m_valid_d = 1'b0;
    per_err_d = per_err_q;
    ovr_d     = ovr_q;

    // Sample accumulation runs in ACQ and DIV so the next period is measured
    // while the divider works on the previous one.
    if (state_q != S_SYNC && ce && !per_end) begin
      peak_d = peak_max;
      cnt_d  = cnt_inc;
    end
    if (per_end) begin
      peak_d = peak_restart;
      cnt_d  = cnt_restart;
    end

    case (state_q)
      S_SYNC: begin
        // Partial first period is discarded.
        if (per_end) begin
          state_d = S_ACQ;
        end
      end

      S_ACQ: begin
        if (per_end) begin
          dvd_d     = {1'b0, pk, 7'd0} + C_BIAS;
          rem_d     = 12'd0;
          quo_d     = 19'd0;
          iter_d    = 5'd0;
          cnt_end_d = cnt_close;
          state_d   = S_DIV;
        end
      end

      S_DIV: begin
        rem_d = div_ge ? div_diff : div_trial[11:0];
        dvd_d = {dvd_q[18:0], 1'b0};
        quo_d = quo_next[18:0];
        // A period closing now cannot be launched; it is dropped.
        if (per_end) begin
          ovr_d = 1'b1;
        end
        if (iter_q == C_LAST) begin
          m_est_d   = (quo_next[19:8] != 12'd0) ? 8'hFF : quo_next[7:0];
          per_err_d = ({1'b0, cnt_end_q} != C_PER);
          m_valid_d = 1'b1;
          state_d   = S_ACQ;
        end else begin
          iter_d = iter_q + 5'd1;
        end
      end

      default: begin
        state_d = S_SYNC;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_SYNC;
      peak_q    <= 12'd0;
      cnt_q     <= 8'd0;
      cnt_end_q <= 8'd0;
      rem_q     <= 12'd0;
      dvd_q     <= 20'd0;
      quo_q     <= 19'd0;
      iter_q    <= 5'd0;
      m_est_q   <= 8'd0;
      m_valid_q <= 1'b0;
      per_err_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      peak_q    <= peak_d;
      cnt_q     <= cnt_d;
      cnt_end_q <= cnt_end_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      quo_q     <= quo_d;
      iter_q    <= iter_d;
      m_est_q   <= m_est_d;
      m_valid_q <= m_valid_d;
      per_err_q <= per_err_d;
      ovr_q     <= ovr_d;
    end
  end

  assign M_est   = m_est_q;
  assign M_valid = m_valid_q;
  assign PER_ERR = per_err_q;
  assign OVR     = ovr_q;
  assign busy    = (state_q == S_DIV);

endmodule
`default_nettype wire
